hero_bus_arbiter: RTL

- Shares a single hero write bus between NUM_REQ requesters.
- Each requester drives hero_write_t-style beats: cycle_type IDLE/VALID/DONE, 36-bit wdat, 7-bit sub_def_t payload.
- The block grants the bus round-robin at transaction boundaries and holds the grant from the first accepted beat through the DONE beat.
- Beats are forwarded through one output register stage with downstream backpressure. Sits between hero producers and the hero bus sink.

---
 rtl/hero_bus_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hero_bus_arbiter.sv
// hero_bus_arbiter
//   Shares one hero write bus between NUM_REQ requesters. The bus is granted
//   round-robin at transaction boundaries and held from the first accepted
//   beat through the DONE beat, or until MAX_BEATS VALID beats have been
//   accepted, whichever comes first. Beats pass through one output register
//   stage that honours downstream backpressure.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_cycle_type    2 bits per requester (IDLE=0, VALID=1, DONE=2)
//   req_wdat          36 bits per requester
//   req_sub           7 bits per requester
//   req_ready         per-requester beat-accepted strobe (combinational)
//   out_cycle_type    registered cycle type on the hero bus
//   out_wdat, out_sub registered data / sub payload
//   out_clk_en        registered, high when out_cycle_type is not IDLE
//   out_ready         sink accepts the current out beat
//   grant_valid       a requester holds the bus
//   grant_id          index of the holder (meaningful when grant_valid)
//   err_overlong      one-cycle pulse after a forced release
module hero_bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GRANT_WIDTH = $clog2(NUM_REQ),
    parameter int MAX_BEATS   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*NUM_REQ-1:0]     req_cycle_type,
    input  logic [36*NUM_REQ-1:0]    req_wdat,
    input  logic [7*NUM_REQ-1:0]     req_sub,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [1:0]               out_cycle_type,
    output logic [35:0]              out_wdat,
    output logic [6:0]               out_sub,
    output logic                     out_clk_en,
    input  logic                     out_ready,
    output logic                     grant_valid,
    output logic [GRANT_WIDTH-1:0]   grant_id,
    output logic                     err_overlong
);

    localparam logic [1:0] CT_IDLE = 2'b00;
    localparam logic [1:0] CT_DONE = 2'b10;
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e                   state_q, state_d;
    logic [GRANT_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [GRANT_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]               beat_cnt_q, beat_cnt_d;
    logic [1:0]               out_type_q, out_type_d;
    logic [35:0]              out_wdat_q, out_wdat_d;
    logic [6:0]               out_sub_q, out_sub_d;
    logic                     out_clk_en_q;
    logic                     err_q, err_d;

    // Per-requester views of the flattened input buses.
    logic [1:0]   req_type_a [NUM_REQ];
    logic [35:0]  req_wdat_a [NUM_REQ];
    logic [6:0]   req_sub_a  [NUM_REQ];
    logic [NUM_REQ-1:0] req_active;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_type_a[gi] = req_cycle_type[2*gi +: 2];
            assign req_wdat_a[gi] = req_wdat[36*gi +: 36];
            assign req_sub_a[gi]  = req_sub[7*gi +: 7];
            assign req_active[gi] = (req_cycle_type[2*gi +: 2] != CT_IDLE);
        end
    endgenerate

    // First active requester at or after the round-robin pointer.
    logic                   pick_found;
    logic [GRANT_WIDTH-1:0] pick_id;

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_active[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_id    = GRANT_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // The out register may take a new value when it is empty or being drained.
    logic load_en;
    assign load_en = (out_type_q == CT_IDLE) | out_ready;

    logic [1:0]  sel_type;
    logic [35:0] sel_wdat;
    logic [6:0]  sel_sub;
    logic [GRANT_WIDTH-1:0] rr_next;

    assign sel_type = req_type_a[grant_id_q];
    assign sel_wdat = req_wdat_a[grant_id_q];
    assign sel_sub  = req_sub_a[grant_id_q];
    assign rr_next  = (int'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        out_type_d = out_type_q;
        out_wdat_d = out_wdat_q;
        out_sub_d  = out_sub_q;
        err_d      = 1'b0;
        req_ready  = '0;

        case (state_q)
            ARB: begin
                if (load_en) begin
                    out_type_d = CT_IDLE;
                    out_wdat_d = '0;
                    out_sub_d  = '0;
                end
                if (pick_found) begin
                    state_d    = LOCKED;
                    grant_id_d = pick_id;
                    beat_cnt_d = '0;
                end
            end
            LOCKED: begin
                req_ready[grant_id_q] = load_en;
                if (load_en) begin
                    // An IDLE from the holder is forwarded as a bubble.
                    out_type_d = sel_type;
                    out_wdat_d = sel_wdat;
                    out_sub_d  = sel_sub;
                    if (sel_type != CT_IDLE) begin
                        if (sel_type == CT_DONE || beat_cnt_q == LAST_BEAT) begin
                            state_d    = ARB;
                            rr_ptr_d   = rr_next;
                            beat_cnt_d = '0;
                            err_d      = (sel_type != CT_DONE);
                        end else begin
                            beat_cnt_d = beat_cnt_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            out_type_q   <= CT_IDLE;
            out_wdat_q   <= '0;
            out_sub_q    <= '0;
            out_clk_en_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            out_type_q   <= out_type_d;
            out_wdat_q   <= out_wdat_d;
            out_sub_q    <= out_sub_d;
            out_clk_en_q <= (out_type_d != CT_IDLE);
            err_q        <= err_d;
        end
    end

    assign out_cycle_type = out_type_q;
    assign out_wdat       = out_wdat_q;
    assign out_sub        = out_sub_q;
    assign out_clk_en     = out_clk_en_q;
    assign grant_valid    = (state_q == LOCKED);
    assign grant_id       = grant_id_q;
    assign err_overlong   = err_q;

endmodule
